// File: rtl/bc_datapath_if.sv
// Controller <-> datapath link: bus select and control slots in, status out.
// Ports: BUS_SEL, CTRL (master drives); IR, CO, Z, N, OVF, E_IN, BUS_OUT (slave drives).
interface bc_datapath_if #(
  parameter int WIDTH      = 16,
  parameter int CTRL_LNGTH = 21
);
  logic [2:0]              BUS_SEL;
  logic [3*CTRL_LNGTH-1:0] CTRL;
  logic [WIDTH-1:0]        IR;
  logic                    CO;
  logic                    Z;
  logic                    N;
  logic                    OVF;
  logic                    E_IN;
  logic [WIDTH-1:0]        BUS_OUT;

  modport master (
    output BUS_SEL, CTRL,
    input  IR, CO, Z, N, OVF, E_IN, BUS_OUT
  );

  modport slave (
    input  BUS_SEL, CTRL,
    output IR, CO, Z, N, OVF, E_IN, BUS_OUT
  );
endinterface

// File: rtl/bc_datapath.sv
// Basic-computer datapath: AR/PC/DR/AC/IR/TR, E, memory, ALU on one common bus.
// Ports: clk, rst_n (sync, active-low), bus (bc_datapath_if.slave).
// Option: BC_SIGNED_OVF_EN enables the signed-overflow flag on ADD.
module bc_datapath #(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 12,
  parameter int CTRL_LNGTH = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  bc_datapath_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [WIDTH-1:0]  D_ONE = WIDTH'(1);

  logic [ADDR_W-1:0] r_ar;
  logic [ADDR_W-1:0] r_pc;
  logic [WIDTH-1:0]  r_dr;
  logic [WIDTH-1:0]  r_ac;
  logic [WIDTH-1:0]  r_ir;
  logic [WIDTH-1:0]  r_tr;
  logic              r_e;
  logic              r_co;
  logic [WIDTH-1:0]  r_mem [2**ADDR_W];

  logic [WIDTH-1:0]  w_bus;
  logic [WIDTH-1:0]  w_mem_rd;
  logic [2:0]        w_op;

  logic w_ar_ld, w_ar_inr, w_ar_clr;
  logic w_pc_ld, w_pc_inr, w_pc_clr;
  logic w_dr_ld, w_dr_inr, w_dr_clr;
  logic w_ac_ld, w_ac_inr, w_ac_clr;
  logic w_ir_ld;
  logic w_tr_ld, w_tr_inr, w_tr_clr;
  logic w_mem_wr;
  logic w_e_cmp, w_e_clr;

  // Upper bits of single-bit slots and slot 17 carry no meaning.
  logic w_unused_ctrl;
  assign w_unused_ctrl = ^bus.CTRL;

  assign w_ar_ld  = bus.CTRL[3*0];
  assign w_ar_inr = bus.CTRL[3*1];
  assign w_ar_clr = bus.CTRL[3*2];
  assign w_pc_ld  = bus.CTRL[3*3];
  assign w_pc_inr = bus.CTRL[3*4];
  assign w_pc_clr = bus.CTRL[3*5];
  assign w_dr_ld  = bus.CTRL[3*6];
  assign w_dr_inr = bus.CTRL[3*7];
  assign w_dr_clr = bus.CTRL[3*8];
  assign w_ac_ld  = bus.CTRL[3*9];
  assign w_ac_inr = bus.CTRL[3*10];
  assign w_ac_clr = bus.CTRL[3*11];
  assign w_ir_ld  = bus.CTRL[3*12];
  assign w_tr_ld  = bus.CTRL[3*13];
  assign w_tr_inr = bus.CTRL[3*14];
  assign w_tr_clr = bus.CTRL[3*15];
  assign w_mem_wr = bus.CTRL[3*16];
  assign w_e_cmp  = bus.CTRL[3*18];
  assign w_e_clr  = bus.CTRL[3*19];
  assign w_op     = bus.CTRL[3*20+2:3*20];

  assign w_mem_rd = r_mem[r_ar];

  always_comb begin
    w_bus = '0;
    case (bus.BUS_SEL)
      3'b000: w_bus = '0;
      3'b001: w_bus = {{(WIDTH-ADDR_W){1'b0}}, r_pc};
      3'b010: w_bus = {{(WIDTH-ADDR_W){1'b0}}, r_ar};
      3'b011: w_bus = r_dr;
      3'b100: w_bus = r_ir;
      3'b101: w_bus = r_ac;
      3'b110: w_bus = w_mem_rd;
      3'b111: w_bus = r_tr;
      default: w_bus = '0;
    endcase
  end

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_e;
  logic             w_alu_vld;
  logic             w_alu_se;

  assign {w_carry, w_sum} = {1'b0, r_ac} + {1'b0, r_dr};

  // w_alu_vld low: AC holds; w_alu_se high: op drives E.
  always_comb begin
    w_alu_res = r_ac;
    w_alu_e   = r_e;
    w_alu_vld = 1'b1;
    w_alu_se  = 1'b0;
    case (w_op)
      3'b000: begin
        w_alu_res = w_sum;
        w_alu_e   = w_carry;
        w_alu_se  = 1'b1;
      end
      3'b001: w_alu_res = r_ac & r_dr;
      3'b010: w_alu_res = r_dr;
      3'b011: w_alu_res = ~r_ac;
      3'b100: begin
        w_alu_res = {r_ac[WIDTH-2:0], r_e};
        w_alu_e   = r_ac[WIDTH-1];
        w_alu_se  = 1'b1;
      end
      3'b101: begin
        w_alu_res = {r_e, r_ac[WIDTH-1:1]};
        w_alu_e   = r_ac[0];
        w_alu_se  = 1'b1;
      end
      default: w_alu_vld = 1'b0;
    endcase
  end

  logic w_add_upd;
  assign w_add_upd = w_ac_ld && (w_op == 3'b000);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ar <= '0;
      r_pc <= '0;
      r_dr <= '0;
      r_ac <= '0;
      r_ir <= '0;
      r_tr <= '0;
      r_e  <= 1'b0;
      r_co <= 1'b0;
    end else begin
      if (w_ar_clr)      r_ar <= '0;
      else if (w_ar_ld)  r_ar <= w_bus[ADDR_W-1:0];
      else if (w_ar_inr) r_ar <= r_ar + A_ONE;

      if (w_pc_clr)      r_pc <= '0;
      else if (w_pc_ld)  r_pc <= w_bus[ADDR_W-1:0];
      else if (w_pc_inr) r_pc <= r_pc + A_ONE;

      if (w_dr_clr)      r_dr <= '0;
      else if (w_dr_ld)  r_dr <= w_bus;
      else if (w_dr_inr) r_dr <= r_dr + D_ONE;

      // A no-op ALU code still blocks AC_INR: the load wins and holds.
      if (w_ac_clr) begin
        r_ac <= '0;
      end else if (w_ac_ld) begin
        if (w_alu_vld) r_ac <= w_alu_res;
      end else if (w_ac_inr) begin
        r_ac <= r_ac + D_ONE;
      end

      if (w_ir_ld) r_ir <= w_bus;

      if (w_tr_clr)      r_tr <= '0;
      else if (w_tr_ld)  r_tr <= w_bus;
      else if (w_tr_inr) r_tr <= r_tr + D_ONE;

      if (w_e_clr)                     r_e <= 1'b0;
      else if (w_e_cmp)                r_e <= ~r_e;
      else if (w_ac_ld && w_alu_se)    r_e <= w_alu_e;

      if (w_add_upd) r_co <= w_carry;
    end
  end

  // Write address is the pre-edge AR, whatever AR does this cycle.
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_wr) r_mem[r_ar] <= w_bus;
  end

`ifdef BC_SIGNED_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_add_upd) begin
      r_ovf <= (r_ac[WIDTH-1] == r_dr[WIDTH-1]) &&
               (w_sum[WIDTH-1] != r_ac[WIDTH-1]);
    end
  end
  assign bus.OVF = r_ovf;
`else
  assign bus.OVF = 1'b0;
`endif

  assign bus.IR      = r_ir;
  assign bus.CO      = r_co;
  assign bus.Z       = (r_ac == '0);
  assign bus.N       = r_ac[WIDTH-1];
  assign bus.E_IN    = r_e;
  assign bus.BUS_OUT = w_bus;

endmodule

// File: tb/tb_bc_datapath.sv
// Bench for bc_datapath: directed scenarios plus random control traffic.
// Registers are observed through BUS_OUT; a spec-level model predicts them.
module tb_bc_datapath;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bc_datapath_if #(.WIDTH(16), .CTRL_LNGTH(21)) bus ();

  bc_datapath #(
    .WIDTH(16), .ADDR_W(12), .CTRL_LNGTH(21)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  localparam int AR_LD = 0, AR_INR = 1, AR_CLR = 2;
  localparam int PC_LD = 3, PC_INR = 4, PC_CLR = 5;
  localparam int DR_LD = 6, DR_INR = 7, DR_CLR = 8;
  localparam int AC_LD = 9, AC_INR = 10, AC_CLR = 11;
  localparam int IR_LD = 12;
  localparam int TR_LD = 13, TR_INR = 14, TR_CLR = 15;
  localparam int MEM_WR = 16, E_CMP = 18, E_CLR = 19;

  // model state
  int m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_e, m_co, m_ovf;
  int m_mem [4096];
  bit m_val [4096];

  function automatic logic [62:0] cb(input int s);
    logic [62:0] v;
    v = '0;
    v[3*s] = 1'b1;
    return v;
  endfunction

  function automatic logic [62:0] op(input int k);
    logic [62:0] v;
    v = '0;
    v[62:60] = 3'(k);
    return v;
  endfunction

  function automatic int model_bus(input int sel);
    case (sel)
      1: return m_pc;
      2: return m_ar;
      3: return m_dr;
      4: return m_ir;
      5: return m_ac;
      6: return m_mem[m_ar];
      7: return m_tr;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input int sel, input logic [62:0] c);
    int b, s, res, ne, o, n_e;
    bit vld, se;
    if (rst) begin
      m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0;
      m_e = 0; m_co = 0; m_ovf = 0;
      return;
    end
    b = model_bus(sel);
    o = int'(c[62:60]);
    s = m_ac + m_dr;
    res = m_ac; ne = m_e; vld = 1; se = 0;
    case (o)
      0: begin res = s % 65536; ne = (s > 65535) ? 1 : 0; se = 1; end
      1: res = m_ac & m_dr;
      2: res = m_dr;
      3: res = 65535 - m_ac;
      4: begin res = (m_ac * 2) % 65536 + m_e; ne = m_ac / 32768; se = 1; end
      5: begin res = m_e * 32768 + m_ac / 2; ne = m_ac % 2; se = 1; end
      default: vld = 0;
    endcase
    if (c[3*MEM_WR]) begin
      m_mem[m_ar] = b;
      m_val[m_ar] = 1;
    end
    n_e = m_e;
    if (c[3*E_CLR]) n_e = 0;
    else if (c[3*E_CMP]) n_e = 1 - m_e;
    else if (c[3*AC_LD] && se) n_e = ne;
    if (c[3*AC_LD] && o == 0) begin
      m_co = (s > 65535) ? 1 : 0;
`ifdef BC_SIGNED_OVF_EN
      m_ovf = ((m_ac / 32768) == (m_dr / 32768) &&
               (res / 32768) != (m_ac / 32768)) ? 1 : 0;
`else
      m_ovf = 0;
`endif
    end
    m_e = n_e;
    if (c[3*AR_CLR]) m_ar = 0;
    else if (c[3*AR_LD]) m_ar = b % 4096;
    else if (c[3*AR_INR]) m_ar = (m_ar + 1) % 4096;
    if (c[3*PC_CLR]) m_pc = 0;
    else if (c[3*PC_LD]) m_pc = b % 4096;
    else if (c[3*PC_INR]) m_pc = (m_pc + 1) % 4096;
    if (c[3*DR_CLR]) m_dr = 0;
    else if (c[3*DR_LD]) m_dr = b;
    else if (c[3*DR_INR]) m_dr = (m_dr + 1) % 65536;
    if (c[3*AC_CLR]) m_ac = 0;
    else if (c[3*AC_LD]) begin if (vld) m_ac = res; end
    else if (c[3*AC_INR]) m_ac = (m_ac + 1) % 65536;
    if (c[3*IR_LD]) m_ir = b;
    if (c[3*TR_CLR]) m_tr = 0;
    else if (c[3*TR_LD]) m_tr = b;
    else if (c[3*TR_INR]) m_tr = (m_tr + 1) % 65536;
  endtask

  task automatic drive(input bit rst, input int sel, input logic [62:0] c);
    @(negedge clk);
    rst_n = ~rst;
    bus.BUS_SEL = 3'(sel);
    bus.CTRL = c;
    @(posedge clk);
    model_edge(rst, sel, c);
    #1;
  endtask

  task automatic step(input int sel, input logic [62:0] c);
    drive(1'b0, sel, c);
  endtask

  task automatic peek(input int sel, output logic [15:0] v);
    @(negedge clk);
    rst_n = 1'b1;
    bus.BUS_SEL = 3'(sel);
    bus.CTRL = '0;
    #1;
    v = bus.BUS_OUT;
  endtask

  // Builds a constant in AC by shifting E into it bit by bit.
  task automatic load_ac(input logic [15:0] k);
    step(0, cb(AC_CLR) | cb(E_CLR));
    for (int i = 15; i >= 0; i--) begin
      step(0, cb(E_CLR));
      if (k[i]) step(0, cb(E_CMP));
      step(0, cb(AC_LD) | op(4));
    end
  endtask

  task automatic test_reset;
    logic [15:0] v;
    drive(1'b1, 0, '0);
    drive(1'b1, 0, '0);
    load_ac(16'h1234);
    step(0, cb(AR_CLR));
    step(5, cb(MEM_WR));
    load_ac(16'h0005);
    step(5, cb(DR_LD) | cb(TR_LD) | cb(IR_LD) | cb(PC_LD) | cb(AR_LD));
    step(0, cb(E_CMP));
    drive(1'b1, 5, cb(AC_INR) | cb(DR_LD));
    peek(2, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL rst_ar got=%h exp=0000", v); end
    peek(1, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0000", v); end
    peek(3, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL rst_dr got=%h exp=0000", v); end
    peek(5, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL rst_ac got=%h exp=0000", v); end
    peek(7, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL rst_tr got=%h exp=0000", v); end
    checks++;
    if (bus.IR !== 16'h0) begin errors++; $display("FAIL rst_ir got=%h exp=0000", bus.IR); end
    checks++;
    if ({bus.E_IN, bus.CO, bus.OVF} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got=%b exp=000", {bus.E_IN, bus.CO, bus.OVF});
    end
    peek(6, v); checks++;
    if (v !== 16'h1234) begin errors++; $display("FAIL rst_mem got=%h exp=1234", v); end
  endtask

  task automatic test_fetch;
    logic [15:0] v;
    load_ac(16'h7800);
    step(5, cb(MEM_WR));
    step(1, cb(AR_LD));
    step(6, cb(IR_LD) | cb(PC_INR));
    peek(2, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL fetch_ar got=%h exp=0000", v); end
    checks++;
    if (bus.IR !== 16'h7800) begin errors++; $display("FAIL fetch_ir got=%h exp=7800", bus.IR); end
    peek(1, v); checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL fetch_pc got=%h exp=0001", v); end
  endtask

  task automatic test_add;
    logic [15:0] v;
    load_ac(16'h0001);
    step(5, cb(DR_LD));
    load_ac(16'hFFFF);
    step(0, cb(AC_LD) | op(0));
    checks++;
    if ({bus.E_IN, bus.CO, bus.Z, bus.OVF} !== 4'b1110) begin
      errors++;
      $display("FAIL add_carry_flags got=%b exp=1110", {bus.E_IN, bus.CO, bus.Z, bus.OVF});
    end
    peek(5, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL add_carry_ac got=%h exp=0000", v); end
    load_ac(16'h7FFF);
    step(0, cb(AC_LD) | op(0));
    peek(5, v); checks++;
    if (v !== 16'h8000) begin errors++; $display("FAIL add_ovf_ac got=%h exp=8000", v); end
    checks++;
`ifdef BC_SIGNED_OVF_EN
    if ({bus.N, bus.CO, bus.OVF} !== 3'b101) begin
      errors++; $display("FAIL add_ovf_flags got=%b exp=101", {bus.N, bus.CO, bus.OVF});
    end
`else
    if ({bus.N, bus.CO, bus.OVF} !== 3'b100) begin
      errors++; $display("FAIL add_ovf_flags got=%b exp=100", {bus.N, bus.CO, bus.OVF});
    end
`endif
  endtask

  task automatic test_shift;
    logic [15:0] v;
    load_ac(16'h8001);
    step(0, cb(E_CLR));
    step(0, cb(AC_LD) | op(4));
    peek(5, v); checks++;
    if ({bus.E_IN, v} !== {1'b1, 16'h0002}) begin
      errors++; $display("FAIL shl got=%b/%h exp=1/0002", bus.E_IN, v);
    end
    step(0, cb(AC_LD) | op(5));
    peek(5, v); checks++;
    if ({bus.E_IN, v} !== {1'b0, 16'h8001}) begin
      errors++; $display("FAIL shr got=%b/%h exp=0/8001", bus.E_IN, v);
    end
  endtask

  task automatic test_priority;
    logic [15:0] v;
    load_ac(16'h1234);
    step(0, cb(AC_CLR) | cb(AC_LD) | cb(AC_INR) | op(2));
    peek(5, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL ac_clr_prio got=%h exp=0000", v); end
    load_ac(16'h00AA);
    step(0, cb(AC_LD) | cb(AC_INR) | op(6));
    peek(5, v); checks++;
    if (v !== 16'h00AA) begin errors++; $display("FAIL ac_noop got=%h exp=00aa", v); end
    load_ac(16'h0FFF);
    step(5, cb(PC_LD));
    step(0, cb(PC_INR));
    peek(1, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL pc_wrap got=%h exp=0000", v); end
    load_ac(16'hFFFF);
    step(0, cb(AC_INR));
    peek(5, v); checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL ac_wrap got=%h exp=0000", v); end
    step(0, cb(E_CLR));
    step(0, cb(E_CMP));
    checks++;
    if (bus.E_IN !== 1'b1) begin errors++; $display("FAIL e_cmp got=%b exp=1", bus.E_IN); end
    step(0, cb(E_CLR) | cb(E_CMP));
    checks++;
    if (bus.E_IN !== 1'b0) begin errors++; $display("FAIL e_clr_prio got=%b exp=0", bus.E_IN); end
  endtask

  task automatic test_memwr;
    logic [15:0] v;
    load_ac(16'h0011);
    step(5, cb(AR_LD));
    load_ac(16'h5A5A);
    step(5, cb(MEM_WR));
    load_ac(16'h0010);
    step(5, cb(AR_LD));
    load_ac(16'hBEEF);
    step(5, cb(MEM_WR) | cb(AR_INR));
    peek(2, v); checks++;
    if (v !== 16'h0011) begin errors++; $display("FAIL memwr_ar got=%h exp=0011", v); end
    peek(6, v); checks++;
    if (v !== 16'h5A5A) begin errors++; $display("FAIL memwr_next got=%h exp=5a5a", v); end
    step(0, cb(AR_INR) | cb(AR_LD) | cb(AR_CLR));
    load_ac(16'h0010);
    step(5, cb(AR_LD));
    peek(6, v); checks++;
    if (v !== 16'hBEEF) begin errors++; $display("FAIL memwr_data got=%h exp=beef", v); end
    load_ac(16'h0030);
    step(5, cb(MEM_WR) | cb(AR_LD));
    load_ac(16'h0010);
    step(5, cb(AR_LD));
    peek(6, v); checks++;
    if (v !== 16'h0030) begin errors++; $display("FAIL memwr_oldar got=%h exp=0030", v); end
  endtask

  task automatic test_random;
    logic [62:0] c;
    logic [15:0] v;
    logic [21:0] st, ex;
    int sel;
    bit rst;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      c = {$urandom, $urandom};
      for (int s = 0; s < 20; s++) c[3*s] = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 6 && !m_val[m_ar]) sel = 5;
      @(negedge clk);
      rst_n = ~rst;
      bus.BUS_SEL = 3'(sel);
      bus.CTRL = c;
      #1;
      v = 16'(model_bus(sel));
      checks++;
      if (bus.BUS_OUT !== v) begin
        errors++; $display("FAIL rnd_bus n=%0d got=%h exp=%h", n, bus.BUS_OUT, v);
      end
      @(posedge clk);
      model_edge(rst, sel, c);
      #1;
      st = {bus.IR, bus.E_IN, bus.CO, bus.OVF, bus.Z, bus.N};
      ex = {16'(m_ir), m_e[0], m_co[0], m_ovf[0], m_ac == 0, m_ac >= 32768};
      checks++;
      if (st !== ex) begin
        errors++; $display("FAIL rnd_status n=%0d got=%h exp=%h", n, st, ex);
      end
    end
    for (int r = 1; r < 8; r++) begin
      if (r == 4 || r == 6) continue;
      peek(r, v);
      checks++;
      if (v !== 16'(model_bus(r))) begin
        errors++; $display("FAIL rnd_reg sel=%0d got=%h exp=%h", r, v, model_bus(r));
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.BUS_SEL = 3'b000;
    bus.CTRL = '0;
    for (int i = 0; i < 4096; i++) begin
      m_mem[i] = 0;
      m_val[i] = 0;
    end
    test_reset;
    test_fetch;
    test_add;
    test_shift;
    test_priority;
    test_memwr;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
